im_boot_sync: RTL and testbench

Parametrised synchronous instruction memory for the pipelined CPU datapath.
- Replaces file-initialised, combinational-read instruction memory with a registered fetch port, a PC-based address map with range/alignment checking, and a streaming boot-load write port.
- Runs a clear/load/run state machine, so programs are loaded at run time by a test bench or loader and not at elaboration.
- Sits between the PC register and the IF/ID pipeline register.

---
 rtl/im_boot_sync.sv | 144 ++++++++++++++
 tb/tb_im_boot_sync.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_boot_sync.sv
// Synchronous instruction memory with a registered fetch port, PC range/alignment checking
// and a streaming boot-load write port, sequenced by a clear/load/run state machine.
module im_boot_sync #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      ADDR_WIDTH   = 10,
  parameter int unsigned      DEPTH        = 1024,
  parameter logic [31:0]      INIT_ADDRESS = 32'h0000_0c00,
  parameter logic [WIDTH-1:0] FILL_WORD    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic [31:0]           pc,
  output logic [WIDTH-1:0]      inst,
  output logic                  inst_valid,
  output logic                  addr_err,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic [WIDTH-1:0]      load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  busy
);

  typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

  localparam logic [ADDR_WIDTH:0] LastIdx  = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [31:0]         ByteSpan = 32'(DEPTH * 4);

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0] load_count_q, load_count_d;
  logic                load_done_q, load_done_d;
  logic [WIDTH-1:0]    inst_q;
  logic                inst_valid_q, addr_err_q;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0]      mem_wdata;

  logic [31:0]           offset;
  logic                  fetch_err;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  fetch_go;
  logic                  start_load;
  logic                  load_ok;

  assign offset    = pc - INIT_ADDRESS;
  assign fetch_err = (pc[1:0] != 2'b00) | (pc < INIT_ADDRESS) | (offset >= ByteSpan);
  assign rd_idx    = offset[ADDR_WIDTH+1:2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_count_d = load_count_q;
    load_done_d  = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = cnt_q[ADDR_WIDTH-1:0];
    mem_wdata    = FILL_WORD;
    load_ok      = 1'b0;
    busy         = 1'b1;
    fetch_go     = 1'b0;
    start_load   = 1'b0;
    unique case (state_q)
      StClear: begin
        mem_we = 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        busy = 1'b0;
        // A load request wins over a fetch presented in the same cycle.
        if (load_start) begin
          start_load   = 1'b1;
          state_d      = StLoad;
          cnt_d        = '0;
          load_count_d = '0;
        end else begin
          fetch_go = fetch_en;
        end
      end
      StLoad: begin
        load_ok = (cnt_q < DepthCnt);
        if (load_valid && load_ok) begin
          mem_we       = 1'b1;
          mem_wdata    = load_data;
          cnt_d        = cnt_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
          if (load_last || (cnt_q == LastIdx)) begin
            state_d     = StRun;
            load_done_d = 1'b1;
          end
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StClear;
      cnt_q        <= '0;
      load_count_q <= '0;
      load_done_q  <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_count_q <= load_count_d;
      load_done_q  <= load_done_d;
      if (fetch_go) begin
        inst_valid_q <= 1'b1;
        addr_err_q   <= fetch_err;
        inst_q       <= fetch_err ? '0 : mem[rd_idx];
      end else if (start_load) begin
        inst_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign load_ready = load_ok;
  assign load_done  = load_done_q;
  assign load_count = load_count_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_im_boot_sync.sv
// Scoreboard bench for im_boot_sync: stimulus pushes expectations from an array model of the
// memory, monitors pop them when fetch results or load_done appear.
module tb_im_boot_sync;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0c00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] inst;
  logic        inst_valid, addr_err;
  logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready, load_done, busy;
  logic [10:0] load_count;

  im_boot_sync dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_en   (fetch_en),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .addr_err   (addr_err),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } fetch_exp_t;

  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  logic [31:0] ref_mem [DEPTH];
  fetch_exp_t  exp_fetch [$];
  int          exp_done [$];
  logic [31:0] words [$];
  bit          fetch_issue = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory map from first principles: word-aligned bytes in [BASE, BASE + 4*DEPTH).
  function automatic fetch_exp_t ref_fetch(input logic [31:0] a);
    fetch_exp_t r;
    if ((a % 4) != 0 || a < BASE || (a - BASE) >= 32'(DEPTH * 4)) begin
      r.err  = 1'b1;
      r.data = '0;
    end else begin
      r.err  = 1'b0;
      r.data = ref_mem[int'((a - BASE) / 4)];
    end
    return r;
  endfunction

  always @(posedge clk) begin : fetch_mon
    fetch_exp_t e;
    if (fetch_issue) begin
      #1;
      if (exp_fetch.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_unexpected: no expectation queued at %0t", $time);
      end else begin
        e = exp_fetch.pop_front();
        check("fetch_inst", inst, e.data);
        check("fetch_valid", inst_valid, 1);
        check("fetch_addr_err", addr_err, e.err);
      end
    end
  end

  always @(posedge clk) begin : done_mon
    #1;
    if (load_done === 1'b1) begin
      done_seen++;
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL load_done_unexpected: pulse with count %0d at %0t", load_count, $time);
      end else begin
        check("load_done_count", load_count, exp_done.pop_front());
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // Counts busy cycles after reset release; optionally pokes load_start mid-clear.
  task automatic wait_clear(input bit poke);
    int n = 0;
    while (busy === 1'b1 && n < 2000) begin
      load_start = poke && (n == 100);
      @(negedge clk);
      n++;
    end
    load_start = 1'b0;
    check("clear_cycles", n, 1024);
    check("busy_after_clear", busy, 0);
  endtask

  task automatic do_fetch(input logic [31:0] a);
    pc          = a;
    fetch_en    = 1'b1;
    fetch_issue = 1'b1;
    exp_fetch.push_back(ref_fetch(a));
    @(negedge clk);
    fetch_en    = 1'b0;
    fetch_issue = 1'b0;
  endtask

  task automatic do_load(input bit use_last, input int gap_at, input bit rand_gaps);
    int idx  = 0;
    bit done = 1'b0;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check("load_count_cleared", load_count, 0);
    check("load_ready_in_load", load_ready, 1);
    check("busy_in_load", busy, 1);
    check("inst_valid_in_load", inst_valid, 0);
    for (int i = 0; i < words.size(); i++) begin
      if (i == gap_at || (rand_gaps && $urandom_range(0, 4) == 0)) begin
        load_valid = 1'b0;
        @(negedge clk);
      end
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = use_last && (i == words.size() - 1);
      if (!done) begin
        ref_mem[idx] = words[i];
        idx++;
        if (load_last || idx == DEPTH) begin
          done = 1'b1;
          exp_done.push_back(idx);
        end
      end
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clk);
    check("busy_after_load", busy, 0);
    check("load_ready_after_load", load_ready, 0);
    check("load_count_after_load", load_count, idx);
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 4))
      0, 1:    return BASE + 32'(4 * $urandom_range(0, 15));
      2:       return BASE + 32'($urandom_range(0, 4095));
      3:       return 32'($urandom_range(0, BASE - 1));
      default: return BASE + 32'h1000 + 32'($urandom_range(0, 64));
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst = 1'b1;
    clear_model();
    #1;
    check("rst_inst", inst, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_count", load_count, 0);
    check("rst_busy", busy, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_clear(1'b0);
    do_fetch(BASE);

    words = {32'h20080005, 32'h20090003, 32'h01095020};
    do_load(1'b1, 1, 1'b0);
    check("load_done_pulses", done_seen, 1);
    do_fetch(32'h0c04);
    do_fetch(32'h0c08);

    do_fetch(32'h0c00);
    pc = 32'h0c08;
    repeat (3) begin
      @(negedge clk);
      check("stall_inst", inst, ref_mem[0]);
      check("stall_valid", inst_valid, 1);
    end

    do_fetch(32'h0c02);
    do_fetch(32'h0bfc);
    do_fetch(32'h1c00);
    do_fetch(32'h1bfc);

    repeat (4) begin
      words.delete();
      repeat ($urandom_range(1, 12)) words.push_back($urandom);
      do_load(1'b1, -1, 1'b1);
      repeat (20) do_fetch(rand_pc());
    end

    words.delete();
    for (int i = 0; i < DEPTH + 1; i++) words.push_back(32'h1000 + 32'(i));
    do_load(1'b0, -1, 1'b0);
    do_fetch(32'h1bfc);
    do_fetch(BASE + 32'h10);

    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = $urandom;
      @(negedge clk);
    end
    rst        = 1'b1;
    load_valid = 1'b0;
    clear_model();
    #1;
    check("midload_busy", busy, 1);
    check("midload_load_count", load_count, 0);
    check("midload_load_ready", load_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_clear(1'b1);
    check("ignored_start_count", load_count, 0);
    repeat (3) begin
      @(negedge clk);
      check("ignored_start_busy", busy, 0);
    end
    do_fetch(BASE);
    do_fetch(BASE + 32'h0ffc);

    repeat (3) @(negedge clk);
    check("fetch_queue_drained", exp_fetch.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
